adc_delay_loader: RTL and testbench

Consumes the 32-bit control word from the ADC0 delay software register and sequences IODELAYE1 tap programming for the ADC data lanes. A rising edge on the word's load bit resets the selected lanes' delay lines and then steps them up to the requested tap with spaced CE pulses. A packed status word is returned for a simulink-to-PPC readback register. The block sits in the user_clk domain between the delay register and the ADC capture IODELAYs.

---
 rtl/adc_delay_loader_pkg.sv | 37 +++
 rtl/adc_delay_loader_if.sv | 23 ++
 rtl/adc_delay_loader.sv | 125 ++++++++++++
 tb/tb_adc_delay_loader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_delay_loader_pkg.sv
// Shared types and field positions for the ADC0 delay loader.
package adc_delay_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    GAP,
    STEP,
    DONE
  } state_e;

  // Control word / status word field positions
  localparam int unsigned TAP_LSB  = 0;
  localparam int unsigned MASK_LSB = 8;
  localparam int unsigned LOAD_BIT = 31;
  localparam int unsigned CNT_LSB  = 16;
  localparam int unsigned BUSY_BIT = 31;

  localparam int unsigned MASK_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned GAP_W  = 4;

  // Assemble the readback word; unused bits stay zero.
  function automatic logic [31:0] pack_status(input logic [4:0]        tap,
                                              input logic [MASK_W-1:0] mask,
                                              input logic [CNT_W-1:0]  cnt,
                                              input logic              busy);
    logic [31:0] s;
    s                    = '0;
    s[TAP_LSB +: 5]      = tap;
    s[MASK_LSB +: MASK_W] = mask;
    s[CNT_LSB +: CNT_W]  = cnt;
    s[BUSY_BIT]          = busy;
    return s;
  endfunction

endpackage

// File: rtl/adc_delay_loader_if.sv
// Bus between the delay register, the loader and the ADC capture IODELAYs.
interface adc_delay_loader_if #(
  parameter int unsigned N_LANES = 8
);
  logic [31:0]        ctrl_word;
  logic [N_LANES-1:0] dly_rst;
  logic [N_LANES-1:0] dly_ce;
  logic               dly_inc;
  logic               busy;
  logic [31:0]        status_word;

  // Register side: drives the control word, consumes delay strobes/status
  modport master (
    output ctrl_word,
    input  dly_rst, dly_ce, dly_inc, busy, status_word
  );

  // Loader side
  modport slave (
    input  ctrl_word,
    output dly_rst, dly_ce, dly_inc, busy, status_word
  );
endinterface

// File: rtl/adc_delay_loader.sv
// Sequences IODELAYE1 reset and CE stepping from the ADC0 delay control word.
module adc_delay_loader
  import adc_delay_pkg::*;
#(
  parameter int unsigned N_LANES    = 8,
  parameter int unsigned TAP_W      = 5,
  parameter int unsigned GAP_CYCLES = 3
) (
  input  logic          user_clk,
  input  logic          user_rst,
  adc_delay_loader_if.slave bus
);

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  state_e              state_q, state_d;
  logic                prev_q;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [TAP_W-1:0]    steps_q, steps_d;
  logic [TAP_W-1:0]    tap_q, tap_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TAP_W-1:0]    st_tap_q, st_tap_d;
  logic [MASK_W-1:0]   st_mask_q, st_mask_d;

  logic                load_bit;
  logic [TAP_W-1:0]    new_tap;
  logic [MASK_W-1:0]   new_mask;
  logic                start;
  logic [N_LANES-1:0]  rst_pulse;
  logic [N_LANES-1:0]  ce_pulse;
  logic                busy;
  logic [31:0]         unused_ctrl;

  assign load_bit    = bus.ctrl_word[LOAD_BIT];
  assign new_tap     = bus.ctrl_word[TAP_LSB +: TAP_W];
  assign new_mask    = bus.ctrl_word[MASK_LSB +: MASK_W];
  assign unused_ctrl = bus.ctrl_word;

  // A start needs a fresh rising edge, an idle FSM and at least one driven lane
  assign start = load_bit && !prev_q && (state_q == IDLE) && (new_mask[N_LANES-1:0] != '0);

  // State and datapath registers
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q   <= IDLE;
      prev_q    <= 1'b1;
      gap_q     <= '0;
      steps_q   <= '0;
      tap_q     <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
      st_tap_q  <= '0;
      st_mask_q <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= load_bit;
      gap_q     <= gap_d;
      steps_q   <= steps_d;
      tap_q     <= tap_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      st_tap_q  <= st_tap_d;
      st_mask_q <= st_mask_d;
    end
  end

  // Next-state logic and per-state lane strobes
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    steps_d   = steps_q;
    tap_d     = tap_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    st_tap_d  = st_tap_q;
    st_mask_d = st_mask_q;
    rst_pulse = '0;
    ce_pulse  = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          tap_d   = new_tap;
          mask_d  = new_mask;
          steps_d = new_tap;
          state_d = RST;
        end
      end
      RST: begin
        rst_pulse = mask_q[N_LANES-1:0];
        gap_d     = GAP_LOAD;
        state_d   = GAP;
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = (steps_q != '0) ? STEP : DONE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      STEP: begin
        ce_pulse = mask_q[N_LANES-1:0];
        steps_d  = steps_q - 1'b1;
        gap_d    = GAP_LOAD;
        state_d  = GAP;
      end
      DONE: begin
        st_tap_d  = tap_q;
        st_mask_d = mask_q;
        cnt_d     = cnt_q + 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy            = (state_q != IDLE);
  assign bus.dly_rst     = rst_pulse;
  assign bus.dly_ce      = ce_pulse;
  assign bus.dly_inc     = 1'b1;
  assign bus.busy        = busy;
  assign bus.status_word = pack_status(5'(st_tap_q), st_mask_q, cnt_q, busy);

endmodule

// File: tb/tb_adc_delay_loader.sv
// Randomized scoreboard bench for adc_delay_loader.
module tb_adc_delay_loader;

  localparam int unsigned NL = 8;
  localparam int unsigned G  = 3;

  logic user_clk = 1'b0;
  logic user_rst = 1'b1;

  adc_delay_loader_if #(.N_LANES(NL)) bus ();

  adc_delay_loader #(
    .N_LANES   (NL),
    .TAP_W     (5),
    .GAP_CYCLES(G)
  ) dut (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .bus      (bus)
  );

  always #5 user_clk = ~user_clk;

  int unsigned cyc = 0;
  always @(posedge user_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_ce;
    int unsigned at;
    logic [7:0]  val;
  } ev_t;

  ev_t expq[$];
  ev_t mon_e;
  bit  mon_en = 1'b0;

  // Reference model of the readback fields
  logic [7:0] cnt_m     = 8'h00;
  logic [4:0] st_tap_m  = 5'h00;
  logic [7:0] st_mask_m = 8'h00;

  function automatic logic [31:0] exp_status(input bit b);
    return (b ? 32'h8000_0000 : 32'h0) | (32'(cnt_m) << 16) | (32'(st_mask_m) << 8) | 32'(st_tap_m);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge user_clk);
  endtask

  // Monitor: every strobe the DUT presents must match the head of the queue
  always @(negedge user_clk) begin
    if (mon_en && (bus.dly_rst != '0 || bus.dly_ce != '0)) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: rst=0x%02h ce=0x%02h, none expected (cycle %0d)",
                 bus.dly_rst, bus.dly_ce, cyc);
      end else begin
        mon_e = expq.pop_front();
        check("pulse_cycle", cyc, mon_e.at);
        if (mon_e.is_ce) begin
          check("ce_lanes", 32'(bus.dly_ce), 32'(mon_e.val));
          check("rst_during_ce", 32'(bus.dly_rst), 32'h0);
        end else begin
          check("rst_lanes", 32'(bus.dly_rst), 32'(mon_e.val));
          check("ce_during_rst", 32'(bus.dly_ce), 32'h0);
        end
      end
    end
  end

  // mode 0: hold ctrl_word; 1: random load toggles and field scrambles; 2: load 0,1,0,1
  task automatic run_load(input logic [4:0] tap, input logic [7:0] mask, input int mode);
    int unsigned c0, done_rel;
    logic [31:0] word, rnd;
    ev_t e;
    word = (32'(mask) << 8) | 32'(tap);
    @(negedge user_clk);
    bus.ctrl_word = word;
    @(negedge user_clk);
    bus.ctrl_word = word | 32'h8000_0000;
    c0 = cyc + 1;
    if (mask == 8'h00) begin
      tick(12);
      check("maskzero_busy", 32'(bus.busy), 32'h0);
      check("maskzero_status", bus.status_word, exp_status(1'b0));
    end else begin
      done_rel = 2 + G + 32'(tap) * (1 + G);
      e.is_ce = 1'b0; e.at = c0; e.val = mask;
      expq.push_back(e);
      for (int k = 0; k < int'(tap); k++) begin
        e.is_ce = 1'b1;
        e.at    = c0 + 2 + G + 32'(k) * (1 + G) - 1;
        e.val   = mask;
        expq.push_back(e);
      end
      for (int unsigned r = 1; r <= done_rel + 1; r++) begin
        @(negedge user_clk);
        if (r == 1) check("busy_start", 32'(bus.busy), 32'h1);
        if (r == done_rel) begin
          check("busy_at_done", 32'(bus.busy), 32'h1);
          check("status_at_done", bus.status_word, exp_status(1'b1));
          cnt_m     = cnt_m + 8'h01;
          st_tap_m  = tap;
          st_mask_m = mask;
        end
        if (r == done_rel + 1) begin
          check("busy_after", 32'(bus.busy), 32'h0);
          check("status_after", bus.status_word, exp_status(1'b0));
        end
        if (mode == 2 && r <= 4) begin
          bus.ctrl_word = (r % 2 == 1) ? word : (word | 32'h8000_0000);
        end else if (mode == 1 && r + 2 <= done_rel && $urandom_range(0, 2) == 0) begin
          rnd = $urandom();
          bus.ctrl_word = {~bus.ctrl_word[31], rnd[30:0]};
        end
      end
    end
  endtask

  task automatic reset_mid_sequence();
    int unsigned c0;
    logic [7:0] mask;
    ev_t e;
    mask = 8'($urandom_range(1, 255));
    @(negedge user_clk);
    bus.ctrl_word = (32'(mask) << 8) | 32'd10;
    @(negedge user_clk);
    bus.ctrl_word = 32'h8000_0000 | (32'(mask) << 8) | 32'd10;
    c0 = cyc + 1;
    e.is_ce = 1'b0; e.at = c0; e.val = mask;
    expq.push_back(e);
    for (int k = 0; k < 10; k++) begin
      e.is_ce = 1'b1; e.at = c0 + 2 + G + 32'(k) * (1 + G) - 1; e.val = mask;
      expq.push_back(e);
    end
    tick(10);
    user_rst = 1'b1;
    expq.delete();
    @(negedge user_clk);
    check("midrst_dly_rst", 32'(bus.dly_rst), 32'h0);
    check("midrst_dly_ce", 32'(bus.dly_ce), 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    check("midrst_status", bus.status_word, 32'h0);
    cnt_m = 8'h00; st_tap_m = 5'h00; st_mask_m = 8'h00;
    user_rst = 1'b0;
    tick(10);
    check("midrst_no_restart", 32'(bus.busy), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ctrl_word = 32'h8000_0305;
    user_rst      = 1'b1;
    tick(3);
    check("reset_dly_rst", 32'(bus.dly_rst), 32'h0);
    check("reset_dly_ce", 32'(bus.dly_ce), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_status", bus.status_word, 32'h0);
    check("reset_dly_inc", 32'(bus.dly_inc), 32'h1);
    user_rst = 1'b0;
    mon_en   = 1'b1;
    tick(10);
    check("load_high_at_reset", 32'(bus.busy), 32'h0);

    run_load(5'd5, 8'h03, 0);
    check("basic_status_const", bus.status_word, 32'h0001_0305);
    run_load(5'd0, 8'h0F, 0);
    run_load(5'd7, 8'h00, 0);
    run_load(5'd31, 8'($urandom_range(1, 255)), 2);
    reset_mid_sequence();
    run_load(5'd10, 8'($urandom_range(1, 255)), 0);

    for (int i = 0; i < 20; i++) begin
      run_load(5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 256; i++) begin
      run_load(5'($urandom_range(0, 1)), 8'($urandom_range(1, 255)), 0);
    end
    check("wrap_count", 32'(bus.status_word[23:16]), 32'(cnt_m));

    tick(5);
    check("missing_pulses", 32'(expq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
